// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// The master drives requests and rsp_ready; the slave answers.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_func3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_func3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_func3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding RV64 data-memory responder with fixed access latency,
// byte-lane extraction/extension and store merging. Macro DMEM_MISALIGN_TRAP_EN enables rsp_err.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [2:0]  func3_q, func3_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rd_word_q;

  logic        accept, done;
  logic [1:0]  size;
  logic [2:0]  off;
  logic        acc_err;
  logic [63:0] shifted;
  logic [63:0] load_res;
  logic [7:0]  byte_mask;
  logic [63:0] bit_mask;
  logic [63:0] wdata_sh;
  logic [63:0] merged;
  logic        addr_unused;

  assign addr_unused = ^bus.req_addr[63:AW+3];

  assign accept = (state_q == IDLE) && bus.req_valid;
  assign done   = (state_q == BUSY) && (cnt_q == 4'd0);

  // State and captured-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      func3_q <= 3'd0;
      idx_q   <= '0;
      off_q   <= 3'd0;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      func3_q <= func3_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory: read is issued at accept so the word is registered during BUSY.
  // A reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_word_q <= mem_q[bus.req_addr[AW+2:3]];
    end
    if (done && !rst && wen_q && !acc_err) begin
      mem_q[idx_q] <= merged;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Access decode: alignment policy depends on the trap build
  always_comb begin
    size    = func3_q[1:0];
    acc_err = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    off = off_q;
    unique case (size)
      2'd0:    acc_err = 1'b0;
      2'd1:    acc_err = off_q[0];
      2'd2:    acc_err = |off_q[1:0];
      default: acc_err = |off_q;
    endcase
    if (!wen_q && (func3_q == 3'd7)) acc_err = 1'b1;
    if (wen_q && func3_q[2])         acc_err = 1'b1;
`else
    unique case (size)
      2'd0:    off = off_q;
      2'd1:    off = {off_q[2:1], 1'b0};
      2'd2:    off = {off_q[2], 2'b00};
      default: off = 3'd0;
    endcase
`endif
  end

  // Load extraction and store merge
  always_comb begin
    shifted = rd_word_q >> {off, 3'b000};
    load_res = shifted;
    unique case (size)
      2'd0: load_res = func3_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_res = func3_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_res = func3_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_res = shifted;
    endcase

    unique case (size)
      2'd0:    byte_mask = 8'h01 << off;
      2'd1:    byte_mask = 8'h03 << off;
      2'd2:    byte_mask = 8'h0F << off;
      default: byte_mask = 8'hFF;
    endcase
    wdata_sh = wdata_q << {off, 3'b000};
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign bit_mask[gi*8 +: 8] = {8{byte_mask[gi]}};
  end

  assign merged = (rd_word_q & ~bit_mask) | (wdata_sh & bit_mask);

  // Request capture and response registers
  always_comb begin
    wen_d   = wen_q;
    func3_d = func3_q;
    idx_d   = idx_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      wen_d   = bus.req_wen;
      func3_d = bus.req_func3;
      idx_d   = bus.req_addr[AW+2:3];
      off_d   = bus.req_addr[2:0];
      wdata_d = bus.req_wdata;
    end
    if (done) begin
      err_d   = acc_err;
      rdata_d = (acc_err || wen_q) ? 64'd0 : load_res;
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: load/store results, latency, backpressure,
// misalignment handling and reset during an in-flight store.
module tb_dmem_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic [63:0] W10_AFTER_SW = 64'h887766554433AA11;
  localparam logic        SW_ERR       = 1'b1;
  localparam logic [63:0] LH13_RES     = 64'h0;
  localparam logic        LH13_ERR     = 1'b1;
  localparam logic [63:0] F7_RES       = 64'h0;
  localparam logic        F7_ERR       = 1'b1;
`else
  localparam logic [63:0] W10_AFTER_SW = 64'h88776655DEADBEEF;
  localparam logic        SW_ERR       = 1'b0;
  localparam logic [63:0] LH13_RES     = 64'hFFFFFFFFFFFFDEAD;
  localparam logic        LH13_ERR     = 1'b0;
  localparam logic [63:0] F7_RES       = 64'h88776655DEADBEEF;
  localparam logic        F7_ERR       = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  dmem_if bus();

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // One complete request/response transaction with latency and handshake checks.
  task automatic do_txn(input string name, input logic wen, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] exp_rdata, input logic exp_err);
    int cycles;
    logic [63:0] got_rdata;
    logic got_err;
    @(negedge clk);
    check({name, ":req_ready_pre"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_wen   = ~wen;
    bus.req_func3 = f3 ^ 3'd5;
    bus.req_addr  = ~addr;
    bus.req_wdata = ~wdata;
    cycles = 0;
    while (!bus.rsp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({name, ":latency"}, 64'(cycles), 64'(LATENCY));
    got_rdata = bus.rsp_rdata;
    got_err   = bus.rsp_err;
    check({name, ":rdata"}, got_rdata, exp_rdata);
    check({name, ":err"}, 64'(got_err), 64'(exp_err));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({name, ":rsp_valid_post"}, 64'(bus.rsp_valid), 64'd0);
    check({name, ":req_ready_post"}, 64'(bus.req_ready), 64'd1);
    $display("[TB] txn %s wen=%0d f3=%0d addr=0x%016h rdata=0x%016h err=%0d lat=%0d",
             name, wen, f3, addr, got_rdata, got_err, cycles);
  endtask

  initial begin
    int cycles;
    logic [63:0] held_rdata;
    logic held_err;

    bus.req_valid = 1'b0;
    bus.req_wen   = 1'b0;
    bus.req_func3 = 3'd0;
    bus.req_addr  = 64'd0;
    bus.req_wdata = 64'd0;
    bus.rsp_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset:req_ready", 64'(bus.req_ready), 64'd1);
    check("reset:rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset:rsp_rdata", bus.rsp_rdata, 64'd0);
    check("reset:rsp_err",   64'(bus.rsp_err), 64'd0);
    rst = 1'b0;
    $display("[TB] txn reset done");

    do_txn("SD_10",  1'b1, 3'd3, 64'h10, 64'h8877665544332211, 64'h0, 1'b0);
    do_txn("LD_10",  1'b0, 3'd3, 64'h10, 64'h0, 64'h8877665544332211, 1'b0);
    do_txn("LB_17",  1'b0, 3'd0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0);
    do_txn("LBU_17", 1'b0, 3'd4, 64'h17, 64'h0, 64'h0000000000000088, 1'b0);
    do_txn("LH_16",  1'b0, 3'd1, 64'h16, 64'h0, 64'hFFFFFFFFFFFF8877, 1'b0);
    do_txn("LWU_14", 1'b0, 3'd6, 64'h14, 64'h0, 64'h0000000088776655, 1'b0);
    do_txn("LW_14",  1'b0, 3'd2, 64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0);
    do_txn("LHU_16", 1'b0, 3'd5, 64'h16, 64'h0, 64'h0000000000008877, 1'b0);
    do_txn("SB_11",  1'b1, 3'd0, 64'h11, 64'hFFFFFFFFFFFFFFAA, 64'h0, 1'b0);
    do_txn("LD_10b", 1'b0, 3'd3, 64'h10, 64'h0, 64'h887766554433AA11, 1'b0);

    // Backpressure: LW response held for 5 cycles while a new request is offered
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_func3 = 3'd2;
    bus.req_addr  = 64'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cycles = 0;
    while (!bus.rsp_valid && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("bp:latency", 64'(cycles), 64'(LATENCY));
    held_rdata = bus.rsp_rdata;
    held_err   = bus.rsp_err;
    check("bp:rdata", held_rdata, 64'h000000004433AA11);
    check("bp:err", 64'(held_err), 64'd0);
    bus.req_valid = 1'b1;
    bus.req_func3 = 3'd3;
    bus.req_addr  = 64'h18;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp:hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp:hold_rdata", bus.rsp_rdata, 64'h000000004433AA11);
      check("bp:hold_err", 64'(bus.rsp_err), 64'd0);
      check("bp:hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("bp:rsp_valid_post", 64'(bus.rsp_valid), 64'd0);
    check("bp:req_ready_post", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp:no_phantom", 64'(bus.rsp_valid), 64'd0);
    end
    $display("[TB] txn BP_LW_10 rdata=0x%016h err=%0d held 5 cycles", held_rdata, held_err);

    do_txn("SW_12",  1'b1, 3'd2, 64'h12, 64'h00000000DEADBEEF, 64'h0, SW_ERR);
    do_txn("LD_10c", 1'b0, 3'd3, 64'h10, 64'h0, W10_AFTER_SW, 1'b0);
    do_txn("LH_13",  1'b0, 3'd1, 64'h13, 64'h0, LH13_RES, LH13_ERR);
    do_txn("F7_10",  1'b0, 3'd7, 64'h10, 64'h0, F7_RES, F7_ERR);
    do_txn("LD_wrap", 1'b0, 3'd3, 64'h10 + 64'(DEPTH * 8), 64'h0, W10_AFTER_SW, 1'b0);
    do_txn("LD_hi",  1'b0, 3'd3, 64'h8000000000000010, 64'h0, W10_AFTER_SW, 1'b0);

    // Reset while a store is in BUSY: the store must be discarded
    do_txn("SD_18",  1'b1, 3'd3, 64'h18, 64'h0123456789ABCDEF, 64'h0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b1;
    bus.req_func3 = 3'd3;
    bus.req_addr  = 64'h18;
    bus.req_wdata = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstbusy:rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rstbusy:req_ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstbusy:no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    $display("[TB] txn RST_BUSY_SD_18 aborted");
    do_txn("LD_18",  1'b0, 3'd3, 64'h18, 64'h0, 64'h0123456789ABCDEF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage.
- Accepts one load/store request at a time on a valid/ready request channel, models a configurable access latency, and returns load data or a store acknowledgement on a valid/ready response channel.
- Performs RV64 byte-lane selection, sign/zero extension and store byte merging inside the responder. The pipeline sees architectural load results directly.

Parameters:
- DEPTH, 1024, number of 64-bit memory words; power of two.
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_wen  in  1  1=store, 0=load
- req_func3  in  3  RV64 funct3 (loads 0..6, stores 0..3)
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  64  extended load result; 0 for stores and errors
- rsp_err  out  1  misaligned access

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; FSM=IDLE; latency counter=0. Memory contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture wen/func3/addr/wdata, load counter with LATENCY-1, go to BUSY.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0: perform the access, register rsp_rdata/rsp_err, set rsp_valid=1, go to RESP.
  - Result: rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid stays 1; rdata and err are held stable until rsp_ready=1.
  - Handshake cycle: clear rsp_valid, go to IDLE.
  - req_ready returns to 1 the cycle after the response handshake. No overlap: at most one outstanding request.
- Word index: addr[log2(DEPTH)+2:3]. Upper address bits are ignored, so out-of-range addresses wrap modulo DEPTH*8.
- Byte offset: addr[2:0].
- Access size from func3[1:0]: 0=byte, 1=half, 2=word, 3=double.
- Alignment rule: offset must be a multiple of the size, otherwise misaligned.
- Loads (func3):
  - 0 LB, 1 LH, 2 LW: sign-extend.
  - 3 LD: full 64 bits.
  - 4 LBU, 5 LHU, 6 LWU: zero-extend.
  - func3=7 is treated as misaligned (err=1).
  - Selected bytes start at the byte offset.
- Stores:
  - func3 0..3; func3 4..7 is treated as misaligned.
  - Low size bytes of wdata are merged into the word at the offset; other bytes are unchanged.
  - The write commits on the BUSY->RESP transition.
  - rsp_rdata=0.
- Misaligned access: no memory write, rsp_rdata=0, rsp_err=1; still completes after the full LATENCY.
- Inputs are sampled only in the accept cycle; req_* changes afterwards have no effect.
- Reset mid-operation: FSM returns to IDLE and any uncommitted store is discarded. A store already committed stays in memory.
- rsp_ready asserted while rsp_valid=0 has no effect.
- LATENCY=1: BUSY lasts one cycle; rsp_valid is high on the cycle after accept.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined: misaligned and undefined-func3 accesses behave as stated in Behaviour (err=1, no write, rdata=0).
- Not defined:
  - rsp_err is tied to 0.
  - Misaligned accesses are force-aligned by clearing the low address bits to the access size, then performed normally.
  - func3=7 loads act as LD; store func3 4..7 act as func3[1:0].

Test Plan:
- SD addr 0x10 wdata 0x8877665544332211, then LD 0x10 -> rsp_rdata=0x8877665544332211, err=0; rsp_valid exactly 2 cycles after each accept with LATENCY=2.
- After that SD: LB 0x17 -> 0xFFFFFFFFFFFFFF88; LBU 0x17 -> 0x0000000000000088; LH 0x16 -> 0xFFFFFFFFFFFF8877; LWU 0x14 -> 0x0000000088776655.
- SB 0x11 wdata 0xFFFFFFFFFFFFFFAA, then LD 0x10 -> 0x887766554433AA11 (only byte 1 changed).
- Hold rsp_ready=0 for 5 cycles during an LW response -> rsp_valid, rdata and err stable throughout, req_ready=0 and a new req_valid is not accepted. Then rsp_ready=1 -> rsp_valid=0 and req_ready=1 on the next cycle.
- With DMEM_MISALIGN_TRAP_EN: SW 0x12 wdata 0xDEADBEEF -> err=1, rdata=0; following LD 0x10 unchanged. Without the macro, the same SW writes at 0x10 -> LD 0x10 = 0x88776655DEADBEEF.
- Assert rst while in BUSY for a store to 0x18 -> rsp_valid stays 0, req_ready=1 after reset, LD 0x18 returns the prior contents.
